// File: rtl/vga_stream_ctrl.sv
// Stream sequencer between the RGB565 pixel FIFO and the VGA/HDMI timing datapath:
// frame-aligned start, underflow recovery, RGB565->RGB888 expansion and status counters.
module vga_stream_ctrl #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned LEVEL_W      = 12,
  parameter int unsigned START_THRESH = 640
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stream_en,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               de_in,
  input  logic [15:0]        fifo_data_in,
  input  logic               fifo_empty,
  input  logic [LEVEL_W-1:0] fifo_level,
  output logic               fifo_read_en,
  output logic               hsync,
  output logic               vsync,
  output logic               dataEnable,
  output logic [23:0]        RGBchannel,
  output logic [2:0]         state_o,
  output logic [15:0]        frame_count,
  output logic [15:0]        underflow_count,
  output logic               frame_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_FILL = 3'd1,
    ARMED     = 3'd2,
    STREAM    = 3'd3,
    RESYNC    = 3'd4
  } state_t;

  localparam logic [18:0]        FRAME_PIXELS = 19'(H_ACTIVE * V_ACTIVE);
  localparam logic [LEVEL_W-1:0] THRESH       = LEVEL_W'(START_THRESH);

  state_t      state;
  state_t      state_next;
  logic        vsync_d;
  logic        frame_start;
  logic        level_ok;
  logic        underflow;
  logic        pop;
  logic [18:0] pixel_count;
  logic [23:0] rgb888;

  // vsync_d resets high so the first cycle after reset never looks like a rising edge
  assign frame_start  = vsync_in & ~vsync_d;
  assign level_ok     = (fifo_level >= THRESH);
  assign underflow    = (state == STREAM) & de_in & fifo_empty;
  assign pop          = (state == STREAM) & de_in & ~fifo_empty;
  assign fifo_read_en = pop;
  assign vsync        = vsync_d;
  assign state_o      = state;

  assign rgb888 = {fifo_data_in[15:11], fifo_data_in[15:13],
                   fifo_data_in[10:5],  fifo_data_in[10:9],
                   fifo_data_in[4:0],   fifo_data_in[4:2]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (stream_en) state_next = WAIT_FILL;
      end
      WAIT_FILL: begin
        if (!stream_en)    state_next = IDLE;
        else if (level_ok) state_next = ARMED;
      end
      ARMED: begin
        if (!stream_en)       state_next = IDLE;
        else if (frame_start) state_next = STREAM;
      end
      STREAM: begin
        // a frame boundary outranks an underflow seen in the same cycle
        if (frame_start)    state_next = stream_en ? STREAM : IDLE;
        else if (underflow) state_next = RESYNC;
      end
      RESYNC: begin
        if (frame_start) begin
          if (!stream_en)    state_next = IDLE;
          else if (level_ok) state_next = STREAM;
          else               state_next = WAIT_FILL;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vsync_d    <= 1'b1;
      hsync      <= 1'b1;
      dataEnable <= 1'b0;
      RGBchannel <= '0;
    end else begin
      vsync_d    <= vsync_in;
      hsync      <= hsync_in;
      dataEnable <= de_in;
      RGBchannel <= pop ? rgb888 : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pixel_count <= '0;
      frame_count <= '0;
      frame_err   <= 1'b0;
    end else begin
      if (frame_start) begin
        pixel_count <= '0;
      end else if (pop) begin
        pixel_count <= pixel_count + 19'd1;
      end
      if (frame_start && (state == STREAM)) begin
        frame_count <= frame_count + 16'd1;
        if (pixel_count != FRAME_PIXELS) frame_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      underflow_count <= '0;
    end else if (underflow && (underflow_count != '1)) begin
      underflow_count <= underflow_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_stream_ctrl.sv
// Randomized bench for vga_stream_ctrl: a reference model predicts pops and status,
// a scoreboard queue carries expected pixels to a monitor that checks the display outputs.
`timescale 1ns/1ps
module tb_vga_stream_ctrl;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int TH = 16;
  localparam int LW = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          stream_en = 1'b0;
  logic          hsync_in = 1'b1;
  logic          vsync_in = 1'b1;
  logic          de_in = 1'b0;
  logic [15:0]   fifo_data_in = '0;
  logic          fifo_empty = 1'b0;
  logic [LW-1:0] fifo_level = '0;
  logic          fifo_read_en;
  logic          hsync;
  logic          vsync;
  logic          dataEnable;
  logic [23:0]   RGBchannel;
  logic [2:0]    state_o;
  logic [15:0]   frame_count;
  logic [15:0]   underflow_count;
  logic          frame_err;

  vga_stream_ctrl #(
    .H_ACTIVE(H), .V_ACTIVE(V), .LEVEL_W(LW), .START_THRESH(TH)
  ) dut (
    .clock(clock), .reset(reset), .stream_en(stream_en),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
    .fifo_data_in(fifo_data_in), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
    .fifo_read_en(fifo_read_en), .hsync(hsync), .vsync(vsync), .dataEnable(dataEnable),
    .RGBchannel(RGBchannel), .state_o(state_o), .frame_count(frame_count),
    .underflow_count(underflow_count), .frame_err(frame_err)
  );

  always #20 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // next-cycle input values, applied by cyc() right after a falling edge
  logic          n_reset = 1'b1;
  logic          n_en = 1'b0;
  logic [LW-1:0] n_level = '0;
  logic          n_empty = 1'b0;
  logic [15:0]   n_data = '0;

  int uf_pix = -1, en_off_pix = -1, reset_line = -1;
  bit color_mode = 1'b0, rand_empty = 1'b0;

  // reference model (state numbers follow the published encoding)
  int          m_state = 0;
  bit          m_vs_prev = 1'b1;
  int          m_pixels = 0;
  logic [15:0] m_frames = '0;
  logic [15:0] m_underflows = '0;
  bit          m_err = 1'b0;
  logic        last_hs = 1'b1, last_vs = 1'b1;
  logic [23:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [23:0] expand(input logic [15:0] d);
    int r = int'(d[15:11]);
    int g = int'(d[10:5]);
    int b = int'(d[4:0]);
    return 24'((r * 8 + r / 4) * 65536 + (g * 4 + g / 16) * 256 + (b * 8 + b / 4));
  endfunction

  task automatic model_step();
    bit fs, pop, uf, enough;
    int nxt;
    chk("state_o", 32'(state_o), 32'(m_state));
    chk("frame_count", 32'(frame_count), 32'(m_frames));
    chk("underflow_count", 32'(underflow_count), 32'(m_underflows));
    chk("frame_err", 32'(frame_err), 32'(m_err));
    fs     = vsync_in && !m_vs_prev;
    pop    = (m_state == 3) && de_in && !fifo_empty;
    uf     = (m_state == 3) && de_in && fifo_empty;
    enough = int'(fifo_level) >= TH;
    chk("fifo_read_en", 32'(fifo_read_en), 32'(pop));
    if (!reset && de_in) exp_q.push_back(pop ? expand(fifo_data_in) : 24'h0);
    last_hs = reset ? 1'b1 : hsync_in;
    last_vs = reset ? 1'b1 : vsync_in;
    if (reset) begin
      m_state = 0; m_vs_prev = 1'b1; m_pixels = 0;
      m_frames = '0; m_underflows = '0; m_err = 1'b0;
    end else begin
      if (uf && m_underflows != 16'hFFFF) m_underflows++;
      if (fs && m_state == 3) begin
        m_frames++;
        if (m_pixels != H * V) m_err = 1'b1;
      end
      if (fs) m_pixels = 0;
      else if (pop) m_pixels++;
      nxt = m_state;
      if (m_state == 0 && stream_en) nxt = 1;
      else if (m_state == 1) nxt = !stream_en ? 0 : (enough ? 2 : 1);
      else if (m_state == 2) nxt = !stream_en ? 0 : (fs ? 3 : 2);
      else if (m_state == 3) nxt = fs ? (stream_en ? 3 : 0) : (uf ? 4 : 3);
      else if (m_state == 4 && fs) nxt = !stream_en ? 0 : (enough ? 3 : 1);
      m_state = nxt;
      m_vs_prev = vsync_in;
    end
  endtask

  task automatic cyc(input logic de, input logic hs, input logic vs);
    @(negedge clock);
    reset = n_reset; stream_en = n_en; fifo_level = n_level;
    fifo_empty = n_empty; fifo_data_in = n_data;
    de_in = de; hsync_in = hs; vsync_in = vs;
    #1;
    model_step();
  endtask

  task automatic pixel(input int p);
    n_empty = (p == uf_pix) || (rand_empty && $urandom_range(23, 0) == 0);
    if (p == en_off_pix) n_en = 1'b0;
    n_data = color_mode ? (((p % 2) != 0) ? 16'h07E0 : 16'hF81F) : 16'($urandom);
    cyc(1'b1, 1'b1, 1'b1);
    n_empty = 1'b0;
  endtask

  task automatic frame(input int npix);
    int p = 0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b1);
    for (int l = 0; l < V; l++) begin
      if (l == reset_line) n_reset = 1'b1;
      cyc(1'b0, 1'b0, 1'b1);
      n_reset = 1'b0;
      cyc(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < H; i++) begin
        if (p < npix) begin
          pixel(p);
          p++;
        end else begin
          cyc(1'b0, 1'b1, 1'b1);
        end
      end
      cyc(1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1);
  endtask

  // monitor: every registered display output is checked on the falling edge
  always @(negedge clock) begin : monitor
    logic [23:0] e;
    chk("dataEnable", 32'(dataEnable), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (dataEnable) chk("RGBchannel", 32'(RGBchannel), 32'(e));
    end
    chk("hsync", 32'(hsync), 32'(last_hs));
    chk("vsync", 32'(vsync), 32'(last_vs));
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with de_in toggling: no pops, outputs at reset values
    n_reset = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'(i % 2), 1'b1, 1'b1);
    n_reset = 1'b0;

    // fill and arm
    n_en = 1'b1; n_level = LW'(TH - 1);
    frame(H * V);
    n_level = LW'(TH);
    idle(3);
    n_level = LW'(TH - 4);
    color_mode = 1'b1;
    frame(H * V);
    color_mode = 1'b0;
    frame(H * V);
    frame(H * V);

    // underflow, then recovery with enough level
    uf_pix = H + 3; n_level = LW'(TH);
    frame(H * V);
    uf_pix = -1;
    frame(H * V);
    frame(H * V);

    // underflow, recovery with low level goes back through WAIT_FILL
    uf_pix = 2;
    frame(H * V);
    uf_pix = -1; n_level = LW'(TH - 1);
    frame(H * V);
    n_level = LW'(TH);
    frame(H * V);
    frame(H * V);

    // graceful stop mid-frame
    en_off_pix = 5;
    frame(H * V);
    en_off_pix = -1;
    frame(H * V);
    idle(4);

    // short frame raises a sticky frame_err
    n_en = 1'b1;
    idle(3);
    frame(H * V);
    frame(H * V);
    frame(20);
    frame(H * V);
    frame(H * V);

    // mid-frame reset during line blanking clears status
    reset_line = 1;
    frame(H * V);
    reset_line = -1;

    // randomized frames
    rand_empty = 1'b1;
    for (int f = 0; f < 70; f++) begin
      n_en       = ($urandom_range(9, 0) != 0);
      n_level    = LW'($urandom_range(TH + 2, TH - 2));
      uf_pix     = ($urandom_range(5, 0) == 0) ? int'($urandom_range(H * V - 1, 0)) : -1;
      en_off_pix = ($urandom_range(9, 0) == 0) ? int'($urandom_range(H * V - 1, 0)) : -1;
      reset_line = ($urandom_range(19, 0) == 0) ? int'($urandom_range(V - 1, 0)) : -1;
      color_mode = ($urandom_range(7, 0) == 0);
      frame(($urandom_range(5, 0) == 0) ? int'($urandom_range(H * V, 0)) : H * V);
    end
    rand_empty = 1'b0; reset_line = -1;

    idle(4);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_stream_ctrl.md
# vga_stream_ctrl

Stream sequencer between the RGB565 pixel FIFO (camera side) and the VGA/HDMI timing datapath. It holds the display black until the FIFO has buffered enough data, starts popping pixels only at a frame boundary, and recovers from FIFO underflow by blanking the rest of the frame and re-arming at the next frame. It expands RGB565 to RGB888 and delays the sync and enable signals so all display outputs stay aligned. It also keeps frame, underflow and alignment status for software and debug.

## Interface
- `H_ACTIVE`, 640, active pixels per line.
- `V_ACTIVE`, 480, active lines per frame.
- `LEVEL_W`, 12, width of `fifo_level`.
- `START_THRESH`, 640, minimum `fifo_level` needed to arm streaming (one line).

Ports:
- `clock` in 1: pixel clock, 25 MHz.
- `reset` in 1: synchronous, active-high.
- `stream_en` in 1: enable streaming. Level-sensitive.
- `hsync_in` in 1: from the timing generator, active-low.
- `vsync_in` in 1: from the timing generator, active-low.
- `de_in` in 1: active-pixel strobe from the timing generator.
- `fifo_data_in` in 16: RGB565 data, first-word-fall-through. Valid whenever `fifo_empty`=0.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_level` in LEVEL_W: FIFO occupancy in words.
- `fifo_read_en` out 1: pop strobe, combinational.
- `hsync` out 1: `hsync_in` delayed 1 cycle.
- `vsync` out 1: `vsync_in` delayed 1 cycle.
- `dataEnable` out 1: `de_in` delayed 1 cycle.
- `RGBchannel` out 24: {R8,G8,B8}.
- `state_o` out 3: current state, for debug.
- `frame_count` out 16: count of frames streamed completely, wraps.
- `underflow_count` out 16: count of underflows, saturates at 16'hFFFF.
- `frame_err` out 1: sticky flag, pixel count mismatch.

## Operation
- **Frame boundary:** `frame_start` = `vsync_in` & ~`vsync_d`, i.e. the rising edge of `vsync_in` (end of the sync pulse). `vsync_d` resets to 1, so reset cannot create a false edge.
- **State encoding:** IDLE=0, WAIT_FILL=1, ARMED=2, STREAM=3, RESYNC=4.
- **Transitions:**
  - IDLE → WAIT_FILL when `stream_en`=1.
  - WAIT_FILL → ARMED when `fifo_level` ≥ START_THRESH.
  - WAIT_FILL → IDLE when `stream_en`=0.
  - ARMED → STREAM on `frame_start`.
  - ARMED → IDLE when `stream_en`=0.
  - ARMED stays in ARMED if the level drops below threshold; the level is not rechecked.
  - STREAM → RESYNC on underflow, i.e. `de_in`=1 and `fifo_empty`=1.
  - STREAM, on `frame_start`:
    - → IDLE if `stream_en`=0;
    - otherwise stay in STREAM. `frame_count`++ and run the pixel check.
  - RESYNC, on `frame_start`:
    - → IDLE if `stream_en`=0;
    - → STREAM if `fifo_level` ≥ START_THRESH;
    - otherwise → WAIT_FILL.
- **Streaming stop:** deasserting `stream_en` while in STREAM takes effect only at the next `frame_start`. A frame is never cut mid-way.
- **Pop:** `fifo_read_en` = (state==STREAM) & `de_in` & ~`fifo_empty`.
- **Pixel count check:**
  - The counter is 19 bits. It increments on each pop and clears on every `frame_start`.
  - At a `frame_start` in STREAM, if count ≠ H_ACTIVE*V_ACTIVE (307200), set `frame_err`.
  - The first `frame_start` after entering STREAM from ARMED or RESYNC is the start of a frame, so it is not checked.
- **Color expansion:** R={d[15:11],d[15:13]}, G={d[10:5],d[10:9]}, B={d[4:0],d[4:2]}.
- **Black output:** `RGBchannel` is 24'h000000 on any cycle without a pop. This includes the underflow pixel, the rest of a RESYNC frame, and all non-STREAM states.
- **Priority:** `reset` > `frame_start` transitions > underflow. A `frame_start` and an underflow in the same cycle: `frame_start` wins and the underflow is still counted.

## Timing
- **Reset values:**
  - `state_o`=0, counters=0, `frame_err`=0.
  - `RGBchannel`=0, `dataEnable`=0, `hsync`=1, `vsync`=1.
  - `fifo_read_en`=0, because state is IDLE.
- **Latency:** `hsync`, `vsync`, `dataEnable` and `RGBchannel` are all registered with 1-cycle latency. A pixel popped in cycle N appears on `RGBchannel` in cycle N+1, together with `dataEnable`=1.
- **FIFO data:** `fifo_data_in` is sampled in the same cycle as `fifo_read_en`.
- **State changes:** transitions take effect on the clock edge after the condition holds. The first pop is in the first `de_in` cycle after the `frame_start` edge.
- **Reset mid-frame:** the block returns to IDLE and stops popping immediately. No partial-frame recovery is attempted.

## Test plan
- **Reset:** assert `reset` for 5 cycles → all outputs at their reset values; `fifo_read_en`=0 while `de_in` toggles.
- **Fill and arm:** `stream_en`=1, `fifo_level` held at 639 → WAIT_FILL, no pops; level set to 640 → ARMED, and the first pop occurs only after the next `vsync_in` rising edge.
- **Color expansion:** `fifo_data_in`=16'hF81F during STREAM → `RGBchannel`=24'hFF00FF, one cycle after the pop; 16'h07E0 → 24'h00FF00.
- **Underflow:** `fifo_empty`=1 mid-line in STREAM → `underflow_count`=1, state=RESYNC, black output for the rest of the frame; at the next frame with level ≥ 640 → STREAM.
- **Graceful stop:** `stream_en`=0 mid-frame → pops continue to the end of the frame; state=IDLE after `frame_start`; `frame_count` incremented by 1.
- **Frame check:** a short frame of 1000 pixels followed by `frame_start` in STREAM → `frame_err`=1, and it stays 1 until `reset`.
